// File: rtl/pico_l15_mem_transducer_if.sv
// ---------------------------------------------------------------------------
// pico_l15_mem_transducer_if
//
// Purpose: bundles the PicoRV32-style memory port and the OpenPiton L1.5
// request/response port of the transducer into one interface.
//
// Modports:
//   slave  - the transducer: it serves core requests and drives L1.5
//            requests and return acknowledgements.
//   master - the environment: the core (or its BFM) plus the L1.5 side.
//
// Handshake semantics:
//   Core side: the core raises mem_valid with addr/wdata/wstrb/amo_op stable
//   and keeps them until it samples mem_ready=1; mem_ready is a one-cycle
//   pulse that carries rdata for loads and AMOs.
//   L1.5 request: transducer_l15_val stays high with every request field
//   stable until the cycle in which l15_transducer_header_ack (or
//   l15_transducer_ack) is sampled high.
//   L1.5 return: every cycle with l15_transducer_val=1 is a return beat and
//   is consumed in that same cycle via transducer_l15_req_ack.
// ---------------------------------------------------------------------------
interface pico_l15_mem_transducer_if;
  // core memory port
  logic        pico_transducer_mem_valid;
  logic [31:0] pico_transducer_mem_addr;
  logic [31:0] pico_transducer_mem_wdata;
  logic [3:0]  pico_transducer_mem_wstrb;
  logic [3:0]  pico_transducer_mem_amo_op;
  logic        transducer_pico_mem_ready;
  logic [31:0] transducer_pico_mem_rdata;
  logic        pico_int;

  // L1.5 request
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic [3:0]  transducer_l15_amo_op;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic        transducer_l15_nc;
  logic        transducer_l15_threadid;
  logic        transducer_l15_prefetch;
  logic        transducer_l15_invalidate_cacheline;
  logic        transducer_l15_blockstore;
  logic        transducer_l15_blockinitstore;
  logic [1:0]  transducer_l15_l1rplway;
  logic [63:0] transducer_l15_data_next_entry;
  logic [32:0] transducer_l15_csm_data;
  logic        l15_transducer_ack;
  logic        l15_transducer_header_ack;

  // L1.5 return
  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic        transducer_l15_req_ack;

  modport slave (
    input  pico_transducer_mem_valid, pico_transducer_mem_addr,
           pico_transducer_mem_wdata, pico_transducer_mem_wstrb,
           pico_transducer_mem_amo_op,
    output transducer_pico_mem_ready, transducer_pico_mem_rdata, pico_int,
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_nc, transducer_l15_threadid, transducer_l15_prefetch,
           transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
           transducer_l15_blockinitstore, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
    input  l15_transducer_ack, l15_transducer_header_ack,
    input  l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
    output transducer_l15_req_ack
  );

  modport master (
    output pico_transducer_mem_valid, pico_transducer_mem_addr,
           pico_transducer_mem_wdata, pico_transducer_mem_wstrb,
           pico_transducer_mem_amo_op,
    input  transducer_pico_mem_ready, transducer_pico_mem_rdata, pico_int,
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_amo_op,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_nc, transducer_l15_threadid, transducer_l15_prefetch,
           transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
           transducer_l15_blockinitstore, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
    output l15_transducer_ack, l15_transducer_header_ack,
    output l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
    input  transducer_l15_req_ack
  );
endinterface

// File: rtl/pico_l15_mem_transducer.sv
// ---------------------------------------------------------------------------
// pico_l15_mem_transducer
//
// Purpose: turns one outstanding PicoRV32-style memory access into an
// OpenPiton L1.5 load / store / atomic request and turns the matching L1.5
// return into read data and a one-cycle mem_ready pulse.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        pico_l15_mem_transducer_if.slave (core port + L1.5 port)
//   dbg_state  current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Build option:
//   PICO_L15_INT_EN  when defined, an INT_RET return produces a one-cycle
//                    pico_int pulse in the following cycle; otherwise
//                    pico_int is tied low and INT_RET is only acknowledged.
// ---------------------------------------------------------------------------
module pico_l15_mem_transducer (
  input  logic                          clk,
  input  logic                          rst_n,
  pico_l15_mem_transducer_if.slave      bus,
  output logic [1:0]                    dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [4:0] RQ_AMO   = 5'b00110;

  localparam logic [3:0] RET_LOAD   = 4'b0000;
  localparam logic [3:0] RET_ST_ACK = 4'b0100;
  localparam logic [3:0] RET_ATOMIC = 4'b1110;

  localparam logic [2:0] SZ_1B = 3'b000;
  localparam logic [2:0] SZ_2B = 3'b001;
  localparam logic [2:0] SZ_4B = 3'b010;

  // The L1.5 is big-endian, the core little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [1:0]  state;
  logic [4:0]  rq_type;
  logic [3:0]  rq_amo;
  logic [2:0]  rq_size;
  logic [39:0] rq_addr;
  logic [63:0] rq_data;
  logic        rq_nc;
  logic [3:0]  exp_ret;   // return type that completes the current access
  logic [1:0]  rd_sel;    // addr[3:2]: which 32-bit word of the 16B return
  logic        mem_ready_q;
  logic [31:0] rdata_q;

  // ---------------- request decode (IDLE, before registering) -------------
  logic        is_amo;
  logic        is_load;
  logic [2:0]  dec_size;
  logic [1:0]  dec_lo;
  logic [4:0]  dec_type;
  logic [3:0]  dec_ret;

  always_comb begin
    is_amo   = bus.pico_transducer_mem_amo_op != 4'd0;
    is_load  = !is_amo && (bus.pico_transducer_mem_wstrb == 4'd0);
    dec_size = SZ_4B;
    dec_lo   = 2'b00;
    dec_type = RQ_STORE;
    dec_ret  = RET_ST_ACK;
    if (is_amo) begin
      dec_type = RQ_AMO;
      dec_ret  = RET_ATOMIC;
    end else if (is_load) begin
      dec_type = RQ_LOAD;
      dec_ret  = RET_LOAD;
    end else begin
      // Sub-word stores address the enabled byte lane directly; any strobe
      // pattern that is not a clean byte or half-word is sent as a full word.
      case (bus.pico_transducer_mem_wstrb)
        4'b0011: begin dec_size = SZ_2B; dec_lo = 2'b00; end
        4'b1100: begin dec_size = SZ_2B; dec_lo = 2'b10; end
        4'b0001: begin dec_size = SZ_1B; dec_lo = 2'b00; end
        4'b0010: begin dec_size = SZ_1B; dec_lo = 2'b01; end
        4'b0100: begin dec_size = SZ_1B; dec_lo = 2'b10; end
        4'b1000: begin dec_size = SZ_1B; dec_lo = 2'b11; end
        default: begin dec_size = SZ_4B; dec_lo = 2'b00; end
      endcase
    end
  end

  // The original low address bits are always replaced by dec_lo.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.pico_transducer_mem_addr[1:0];

  // ---------------- handshake terms ---------------------------------------
  logic accept;
  logic hdr_ack;
  logic ret_hit;
  logic complete;

  // The !mem_ready guard keeps a core that still holds valid during the
  // ready pulse from starting the same access twice.
  assign accept   = (state == ST_IDLE) && bus.pico_transducer_mem_valid && !mem_ready_q;
  assign hdr_ack  = bus.l15_transducer_header_ack | bus.l15_transducer_ack;
  assign ret_hit  = bus.l15_transducer_val && (bus.l15_transducer_returntype == exp_ret);
  // A return in the same cycle as the header ack must not be lost.
  assign complete = ((state == ST_REQ) && hdr_ack && ret_hit) ||
                    ((state == ST_WAIT) && ret_hit);

  logic [63:0] ret_dw;
  logic [31:0] ret_w;
  assign ret_dw = rd_sel[1] ? bus.l15_transducer_data_1 : bus.l15_transducer_data_0;
  assign ret_w  = rd_sel[0] ? ret_dw[31:0] : ret_dw[63:32];

  // ---------------- FSM and request registers -----------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rq_type     <= 5'd0;
      rq_amo      <= 4'd0;
      rq_size     <= 3'd0;
      rq_addr     <= 40'd0;
      rq_data     <= 64'd0;
      rq_nc       <= 1'b0;
      exp_ret     <= 4'd0;
      rd_sel      <= 2'd0;
      mem_ready_q <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      mem_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rq_type <= dec_type;
            rq_amo  <= bus.pico_transducer_mem_amo_op;
            rq_size <= dec_size;
            rq_addr <= {{8{bus.pico_transducer_mem_addr[31]}},
                        bus.pico_transducer_mem_addr[31:2], dec_lo};
            rq_data <= {bswap32(bus.pico_transducer_mem_wdata),
                        bswap32(bus.pico_transducer_mem_wdata)};
            rq_nc   <= bus.pico_transducer_mem_addr[31] | is_amo;
            exp_ret <= dec_ret;
            rd_sel  <= bus.pico_transducer_mem_addr[3:2];
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (hdr_ack) state <= complete ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (complete) state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (complete) begin
        mem_ready_q <= 1'b1;
        // Store acks carry no data; rdata keeps the last load/AMO value.
        if (exp_ret != RET_ST_ACK) rdata_q <= bswap32(ret_w);
      end
    end
  end

  // ---------------- interrupt --------------------------------------------
`ifdef PICO_L15_INT_EN
  localparam logic [3:0] RET_INT = 4'b0111;
  logic int_q;
  always_ff @(posedge clk) begin
    if (!rst_n) int_q <= 1'b0;
    else        int_q <= bus.l15_transducer_val &&
                         (bus.l15_transducer_returntype == RET_INT);
  end
  assign bus.pico_int = int_q;
`else
  assign bus.pico_int = 1'b0;
`endif

  // ---------------- outputs ----------------------------------------------
  assign bus.transducer_pico_mem_ready = mem_ready_q;
  assign bus.transducer_pico_mem_rdata = rdata_q;

  assign bus.transducer_l15_val     = (state == ST_REQ);
  assign bus.transducer_l15_rqtype  = rq_type;
  assign bus.transducer_l15_amo_op  = rq_amo;
  assign bus.transducer_l15_size    = rq_size;
  assign bus.transducer_l15_address = rq_addr;
  assign bus.transducer_l15_data    = rq_data;
  assign bus.transducer_l15_nc      = rq_nc;

  assign bus.transducer_l15_threadid             = 1'b0;
  assign bus.transducer_l15_prefetch             = 1'b0;
  assign bus.transducer_l15_invalidate_cacheline = 1'b0;
  assign bus.transducer_l15_blockstore           = 1'b0;
  assign bus.transducer_l15_blockinitstore       = 1'b0;
  assign bus.transducer_l15_l1rplway             = 2'b00;
  assign bus.transducer_l15_data_next_entry      = 64'd0;
  assign bus.transducer_l15_csm_data             = 33'd0;

  // Every return beat is consumed immediately; unexpected ones are dropped.
  assign bus.transducer_l15_req_ack = bus.l15_transducer_val;

  assign dbg_state = state;

endmodule

// File: tb/tb_pico_l15_mem_transducer.sv
// ---------------------------------------------------------------------------
// tb_pico_l15_mem_transducer
//
// Directed bench for pico_l15_mem_transducer: a core driver, an L1.5
// responder, a request/read-data model and a per-cycle compare process.
// ---------------------------------------------------------------------------
module tb_pico_l15_mem_transducer;

`ifdef PICO_L15_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  localparam logic [3:0] T_LOAD  = 4'b0000;
  localparam logic [3:0] T_STACK = 4'b0100;
  localparam logic [3:0] T_INT   = 4'b0111;
  localparam logic [3:0] T_EVICT = 4'b0011;

  // ---------------- clock / reset ----------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pico_l15_mem_transducer_if bus();
  logic [1:0] dbg_state;

  pico_l15_mem_transducer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- model -------------------------------------------------
  logic [4:0]  m_rqtype;
  logic [2:0]  m_size;
  logic [39:0] m_addr;
  logic        m_nc;
  logic [63:0] m_data;
  logic [3:0]  m_amo;
  logic [3:0]  m_ret;
  logic [31:0] m_last_rdata = 32'd0;
  logic [31:0] exp_q[$];

  task automatic model_req(input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic [3:0] amo);
    int ones;
    int low;
    logic [1:0] lo;
    logic [31:0] sw;
    ones = $countones(ws);
    low = 0;
    for (int i = 3; i >= 0; i--) if (ws[i]) low = i;
    lo = 2'b00;
    if (amo != 4'd0) begin
      m_rqtype = 5'd6; m_ret = 4'he; m_size = 3'd2;
    end else if (ws == 4'd0) begin
      m_rqtype = 5'd0; m_ret = T_LOAD; m_size = 3'd2;
    end else begin
      m_rqtype = 5'd1; m_ret = T_STACK;
      if (ones == 1) begin
        m_size = 3'd0; lo = low[1:0];
      end else if (ws == 4'b0011 || ws == 4'b1100) begin
        m_size = 3'd1; lo = low[1:0];
      end else begin
        m_size = 3'd2;
      end
    end
    m_addr = {{8{a[31]}}, a[31:2], lo};
    m_nc   = a[31] | (amo != 4'd0);
    m_amo  = amo;
    for (int i = 0; i < 4; i++) sw[8*(3-i) +: 8] = wd[8*i +: 8];
    m_data = {sw, sw};
  endtask

  // The 16-byte return line is big-endian: byte 0 is data_0[63:56].
  function automatic logic [31:0] model_rdata(input logic [31:0] a,
                                              input logic [63:0] d0,
                                              input logic [63:0] d1);
    logic [127:0] flat;
    logic [7:0] line [16];
    int o;
    flat = {d0, d1};
    for (int k = 0; k < 16; k++) line[k] = flat[127 - 8*k -: 8];
    o = 4 * int'(a[3:2]);
    return {line[o+3], line[o+2], line[o+1], line[o]};
  endfunction

  // ---------------- compare process --------------------------------------
  int   req_count = 0;
  int   ready_count = 0;
  int   int_pulses = 0;
  logic prev_val = 1'b0;
  logic int_exp = 1'b0;

  always @(negedge clk) begin
    chk("req_ack", bus.transducer_l15_req_ack, bus.l15_transducer_val);
    chk("tieoffs", |{bus.transducer_l15_threadid, bus.transducer_l15_prefetch,
                     bus.transducer_l15_invalidate_cacheline, bus.transducer_l15_blockstore,
                     bus.transducer_l15_blockinitstore, bus.transducer_l15_l1rplway,
                     bus.transducer_l15_data_next_entry, bus.transducer_l15_csm_data}, 0);
    if (bus.transducer_l15_val) begin
      chk("rq_addr",   bus.transducer_l15_address, m_addr);
      chk("rq_type",   bus.transducer_l15_rqtype,  m_rqtype);
      chk("rq_size",   bus.transducer_l15_size,    m_size);
      chk("rq_nc",     bus.transducer_l15_nc,      m_nc);
      chk("rq_data",   bus.transducer_l15_data,    m_data);
      chk("rq_amo_op", bus.transducer_l15_amo_op,  m_amo);
    end
    if (bus.transducer_l15_val && !prev_val) req_count++;
    prev_val = bus.transducer_l15_val;
    if (bus.transducer_pico_mem_ready) begin
      ready_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got mem_ready=1 expected 0");
      end else begin
        chk("rdata", bus.transducer_pico_mem_rdata, exp_q.pop_front());
      end
    end
    chk("pico_int", bus.pico_int, int_exp);
    if (bus.pico_int) int_pulses++;
    int_exp = INT_EN && rst_n && bus.l15_transducer_val &&
              (bus.l15_transducer_returntype == T_INT);
  end

  // ---------------- driver tasks -----------------------------------------
  logic [39:0] cap_addr;
  logic [4:0]  cap_type;
  logic [2:0]  cap_size;
  logic        cap_nc;
  logic [63:0] cap_data;
  logic [31:0] cap_rdata;
  int          val_cycles;

  task automatic clear_ret;
    bus.l15_transducer_val        = 1'b0;
    bus.l15_transducer_returntype = 4'd0;
    bus.l15_transducer_data_0     = 64'd0;
    bus.l15_transducer_data_1     = 64'd0;
  endtask

  task automatic drive_ret(input logic [3:0] t, input logic [63:0] d0, input logic [63:0] d1);
    bus.l15_transducer_val        = 1'b1;
    bus.l15_transducer_returntype = t;
    bus.l15_transducer_data_0     = d0;
    bus.l15_transducer_data_1     = d1;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [3:0] amo,
                        input int ack_dly, input int ret_dly,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input bit extra, input logic [3:0] extra_type);
    int req0;
    int rdy0;
    int n;
    logic [3:0] rtype;
    model_req(a, wd, ws, amo);
    rtype = m_ret;
    if (m_ret != T_STACK) m_last_rdata = model_rdata(a, d0, d1);
    exp_q.push_back(m_last_rdata);
    req0 = req_count;
    rdy0 = ready_count;
    bus.pico_transducer_mem_valid  = 1'b1;
    bus.pico_transducer_mem_addr   = a;
    bus.pico_transducer_mem_wdata  = wd;
    bus.pico_transducer_mem_wstrb  = ws;
    bus.pico_transducer_mem_amo_op = amo;
    tick;
    chk("val_rise", bus.transducer_l15_val, 1);
    cap_addr = bus.transducer_l15_address;
    cap_type = bus.transducer_l15_rqtype;
    cap_size = bus.transducer_l15_size;
    cap_nc   = bus.transducer_l15_nc;
    cap_data = bus.transducer_l15_data;
    val_cycles = 1;
    repeat (ack_dly) begin
      tick;
      if (bus.transducer_l15_val) val_cycles++;
    end
    bus.l15_transducer_header_ack = 1'b1;
    if (ret_dly == 0) drive_ret(rtype, d0, d1);
    tick;
    bus.l15_transducer_header_ack = 1'b0;
    clear_ret();
    if (ret_dly != 0) begin
      if (extra) begin
        drive_ret(extra_type, ~d0, ~d1);
        tick;
        clear_ret();
      end
      repeat (ret_dly - 1) tick;
      drive_ret(rtype, d0, d1);
      tick;
      clear_ret();
    end
    n = 0;
    while (!bus.transducer_pico_mem_ready && n < 8) begin
      tick;
      n++;
    end
    if (!bus.transducer_pico_mem_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no mem_ready within 8 cycles");
    end else begin
      cap_rdata = bus.transducer_pico_mem_rdata;
      tick;  // valid still held across the ready cycle
    end
    bus.pico_transducer_mem_valid  = 1'b0;
    bus.pico_transducer_mem_wstrb  = 4'd0;
    bus.pico_transducer_mem_amo_op = 4'd0;
    repeat (3) tick;
    chk("one_request", req_count - req0, 1);
    chk("one_ready", ready_count - rdy0, 1);
  endtask

  task automatic check_outputs_zero(input string p);
    chk({p, "_val"},    bus.transducer_l15_val, 0);
    chk({p, "_addr"},   bus.transducer_l15_address, 0);
    chk({p, "_rqtype"}, bus.transducer_l15_rqtype, 0);
    chk({p, "_size"},   bus.transducer_l15_size, 0);
    chk({p, "_data"},   bus.transducer_l15_data, 0);
    chk({p, "_nc"},     bus.transducer_l15_nc, 0);
    chk({p, "_amo"},    bus.transducer_l15_amo_op, 0);
    chk({p, "_ready"},  bus.transducer_pico_mem_ready, 0);
    chk({p, "_rdata"},  bus.transducer_pico_mem_rdata, 0);
    chk({p, "_int"},    bus.pico_int, 0);
  endtask

  // ---------------- stimulus ---------------------------------------------
  initial begin
    int ip0;
    int req0;
    bus.pico_transducer_mem_valid  = 1'b0;
    bus.pico_transducer_mem_addr   = 32'd0;
    bus.pico_transducer_mem_wdata  = 32'd0;
    bus.pico_transducer_mem_wstrb  = 4'd0;
    bus.pico_transducer_mem_amo_op = 4'd0;
    bus.l15_transducer_ack         = 1'b0;
    bus.l15_transducer_header_ack  = 1'b0;
    clear_ret();

    repeat (3) tick;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick;

    // Load, little-endian word extraction
    access(32'h0000_1004, 32'd0, 4'b0000, 4'd0, 0, 1,
           64'h1122_3344_5566_7788, 64'h0, 1'b0, 4'd0);
    chk("ld_addr",  cap_addr, 40'h00_0000_1004);
    chk("ld_size",  cap_size, 3'b010);
    chk("ld_nc",    cap_nc, 0);
    chk("ld_rdata", cap_rdata, 32'h8877_6655);

    // Full-word store to the non-cacheable upper half
    access(32'h8000_0010, 32'hAABB_CCDD, 4'b1111, 4'd0, 0, 2,
           64'h0, 64'h0, 1'b0, 4'd0);
    chk("st_addr",   cap_addr, 40'hFF_8000_0010);
    chk("st_nc",     cap_nc, 1);
    chk("st_rqtype", cap_type, 5'd1);
    chk("st_data",   cap_data, 64'hDDCC_BBAA_DDCC_BBAA);
    chk("st_rdata_kept", cap_rdata, 32'h8877_6655);

    // Byte and half-word stores
    access(32'h0000_0020, 32'h1234_5678, 4'b0100, 4'd0, 0, 1, 64'h0, 64'h0, 1'b0, 4'd0);
    chk("sb_size", cap_size, 3'b000);
    chk("sb_addr", cap_addr, 40'h22);
    access(32'h0000_0020, 32'h1234_5678, 4'b1100, 4'd0, 0, 1, 64'h0, 64'h0, 1'b0, 4'd0);
    chk("sh_size", cap_size, 3'b001);
    chk("sh_addr", cap_addr, 40'h22);
    access(32'h0000_0033, 32'h0000_00EE, 4'b1000, 4'd0, 0, 1, 64'h0, 64'h0, 1'b0, 4'd0);
    chk("sb3_addr", cap_addr, 40'h33);
    access(32'h0000_0042, 32'hCAFE_F00D, 4'b0101, 4'd0, 0, 1, 64'h0, 64'h0, 1'b0, 4'd0);
    chk("odd_strobe_size", cap_size, 3'b010);
    chk("odd_strobe_addr", cap_addr, 40'h40);

    // Header ack held off for 5 cycles: request must stay up for 6
    access(32'h0000_0108, 32'd0, 4'b0000, 4'd0, 5, 3,
           64'h0, 64'hA1A2_A3A4_B1B2_B3B4, 1'b0, 4'd0);
    chk("hold_cycles", val_cycles, 6);
    chk("ld_word2_rdata", cap_rdata, 32'hA4A3_A2A1);

    // Interrupt return while waiting for a load
    ip0 = int_pulses;
    access(32'h0000_020C, 32'd0, 4'b0000, 4'd0, 0, 3,
           64'h0, 64'h0102_0304_0506_0708, 1'b1, T_INT);
    chk("int_pulses", int_pulses - ip0, INT_EN ? 1 : 0);
    chk("int_ld_rdata", cap_rdata, 32'h0807_0605);

    // Unexpected (eviction) return while waiting is discarded
    access(32'h0000_0300, 32'd0, 4'b0000, 4'd0, 1, 2,
           64'hDEAD_BEEF_0000_0000, 64'h0, 1'b1, T_EVICT);
    chk("evict_rdata", cap_rdata, 32'hEFBE_ADDE);

    // Store ack-type return while waiting for a load is also discarded
    access(32'h0000_0304, 32'd0, 4'b0000, 4'd0, 0, 2,
           64'h0000_0000_1357_9BDF, 64'h0, 1'b1, T_STACK);
    chk("stack_on_load_rdata", cap_rdata, 32'hDF9B_5713);

    // AMO: non-cacheable, op forwarded, returned data goes to rdata
    access(32'h0000_0404, 32'h0000_0001, 4'b1111, 4'd3, 0, 1,
           64'h0000_0000_0000_002A, 64'h0, 1'b0, 4'd0);
    chk("amo_rqtype", cap_type, 5'b00110);
    chk("amo_nc",     cap_nc, 1);
    chk("amo_rdata",  cap_rdata, 32'h2A00_0000);

    // Return in the same cycle as the header ack
    access(32'h0000_0500, 32'd0, 4'b0000, 4'd0, 0, 0,
           64'h7766_5544_3322_1100, 64'h0, 1'b0, 4'd0);
    chk("same_cycle_rdata", cap_rdata, 32'h4455_6677);

    // Return arriving while idle: acknowledged, no completion
    drive_ret(T_LOAD, 64'h1, 64'h2);
    tick;
    clear_ret();
    repeat (2) tick;

    // Reset while waiting for a load, with its return in flight
    req0 = req_count;
    model_req(32'h0000_0040, 32'd0, 4'b0000, 4'd0);
    bus.pico_transducer_mem_valid = 1'b1;
    bus.pico_transducer_mem_addr  = 32'h0000_0040;
    tick;
    bus.l15_transducer_header_ack = 1'b1;
    tick;
    bus.l15_transducer_header_ack = 1'b0;
    tick;
    rst_n = 1'b0;
    bus.pico_transducer_mem_valid = 1'b0;
    drive_ret(T_LOAD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    tick;
    check_outputs_zero("mid_reset");
    chk("mid_reset_req_ack", bus.transducer_l15_req_ack, 1);
    chk("mid_reset_one_request", req_count - req0, 1);
    clear_ret();
    rst_n = 1'b1;
    m_last_rdata = 32'd0;
    repeat (2) tick;

    // Access after reset completes normally
    access(32'h0000_0048, 32'd0, 4'b0000, 4'd0, 0, 1,
           64'h0, 64'h0BAD_F00D_600D_CAFE, 1'b0, 4'd0);
    chk("post_reset_rdata", cap_rdata, 32'h0DF0_AD0B);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
